alu16_sequencer: RTL and testbench
==================================

Name: alu16_sequencer

Overview:
- Multi-cycle front-end sitting directly upstream of the 8-bit ALU.
- Accepts one 16-bit arithmetic request per handshake (ADD16/SUB16/INC16/DEC16, as used by ADD HL,rr / SBC-free 16-bit paths / INC rr / DEC rr).
- Sequences it as 2–3 byte-wide ALU operations, capturing the ALU's out and status_flag each cycle.
- Presents the 16-bit result plus a composed flag byte to register-file writeback through a valid/ready handshake.

Parameters:
- WORD_WIDTH, 16, request/result width; must equal 2*BYTE_WIDTH.
- BYTE_WIDTH, 8, ALU datapath width; drives the ALU's alu_width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept (high only in IDLE).
- req_op  input  2  0=ADD16, 1=SUB16, 2=INC16, 3=DEC16.
- req_a  input  16  operand A.
- req_b  input  16  operand B (ignored for INC16/DEC16).
- alu_a  output  8  ALU operand a.
- alu_b  output  8  ALU operand b.
- alu_opcode  output  alu_op  ALU opcode (ADD/SUB/INC/DEC only).
- alu_enable  output  1  high only in LO/HI/ADJ.
- alu_out  input  8  ALU result.
- alu_flags  input  8  ALU status_flag (bit0 C, bit4 H, bit6 Z, bit7 S).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  writeback consumes result.
- rsp_data  output  16  result word.
- rsp_flags  output  8  composed flags, same bit layout as ALU.
- rsp_flags_we  output  1  1 for ADD16/SUB16; 0 for INC16/DEC16 (flags unaffected).

Behaviour:
- Reset (async, any state): state=IDLE, all latches cleared. Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_flags_we=0, alu_enable=0, alu_a=alu_b=0, alu_opcode=ADD. An in-flight request is dropped; no partial result is emitted.
- States: IDLE, LO, HI, ADJ, DONE. Exactly one ALU op per LO/HI/ADJ cycle. ALU is combinational, so alu_out/alu_flags are sampled at the end of the same cycle.
- IDLE:
  - req_valid&req_ready latches op, A, B; next state LO.
  - Without a handshake, stays in IDLE.
- LO:
  - ADD16/SUB16: alu_opcode=ADD/SUB, alu_a=A[7:0], alu_b=B[7:0].
  - INC16/DEC16: alu_opcode=INC/DEC, alu_a=A[7:0], alu_b=1.
  - Latch res_lo=alu_out, c_lo=alu_flags[0]; next state HI.
- HI:
  - ADD16/SUB16: ADD/SUB on A[15:8], B[15:8]; latch res_hi, c_hi, h_hi. Next state ADJ if c_lo, else DONE.
  - INC16/DEC16: if c_lo, go to ADJ with res_hi=A[15:8] and alu_enable=0 this cycle; else res_hi=A[15:8], go to DONE.
- ADJ:
  - INC (ADD16/INC16) or DEC (SUB16/DEC16) on res_hi, propagating the low-byte carry/borrow.
  - Latch res_hi=alu_out, c_adj=alu_flags[0]; next state DONE.
- DONE:
  - rsp_valid=1, rsp_data={res_hi,res_lo}.
  - rsp_flags: C=c_hi|c_adj, N=(op==SUB16), Z=(rsp_data==0), S=rsp_data[15], bits 5/3=0, P/V=0. H per Optional Feature.
  - Held stable while rsp_ready=0. Returns to IDLE on rsp_ready; req_ready is asserted the following cycle.
- Latency (accept edge to rsp_valid): 3 cycles without ADJ, 4 with ADJ.
- Wrap-around: all 16-bit arithmetic is modulo 2^16. 0xFFFF+1 → 0x0000 with C=1; 0x0000−1 → 0xFFFF with C=1.
- Simultaneous req_valid in DONE is ignored (req_ready=0). No request overlap; throughput is one request per 4–6 cycles.

Optional Feature:
- Macro: ALU16_SEQ_HALF_CARRY_EN.
- Defined: rsp_flags[4] (H) = carry out of bit 11. For ADD16/SUB16 this is h_hi from HI, OR'd with alu_flags[4] from ADJ when ADJ runs.
- Undefined: rsp_flags[4] = 0 and no half-carry state is held.
- All other behaviour is identical in both builds.

Test Plan:
- ADD16 0x00FF+0x0001 → LO,HI,ADJ visited; rsp_data=0x0100, C=0, Z=0, S=0, N=0, flags_we=1, rsp_valid 4 cycles after accept.
- ADD16 0xFFFF+0x0001 → rsp_data=0x0000, C=1, Z=1, S=0. With ALU16_SEQ_HALF_CARRY_EN: H=1.
- SUB16 0x1234−0x0034 → no ADJ, latency 3, rsp_data=0x1200, C=0, N=1. SUB16 0x0000−0x0001 → rsp_data=0xFFFF, C=1, S=1, N=1.
- INC16 0x00FF → 0x0100, flags_we=0. DEC16 0x0100 → 0x00FF, flags_we=0. DEC16 0x0000 → 0xFFFF.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_data/rsp_flags stable, req_ready=0 while req_valid=1. Release → IDLE, next request accepted.
- Assert reset during HI of ADD16 0x00FF+0x0001 → immediately rsp_valid=0, alu_enable=0, req_ready=1. No response is ever produced for that request; the next request completes correctly.

Source files
------------

// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - sequences 16-bit ADD/SUB/INC/DEC requests onto an 8-bit combinational ALU
// Optional: define ALU16_SEQ_HALF_CARRY_EN to report the carry out of bit 11 in rsp_flags[4].
module alu16_sequencer #(
    parameter int WORD_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [WORD_WIDTH-1:0] req_a,
    input  logic [WORD_WIDTH-1:0] req_b,
    output logic [BYTE_WIDTH-1:0] alu_a,
    output logic [BYTE_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_opcode,
    output logic                  alu_enable,
    input  logic [BYTE_WIDTH-1:0] alu_out,
    input  logic [7:0]            alu_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_data,
    output logic [7:0]            rsp_flags,
    output logic                  rsp_flags_we
);

    localparam logic [1:0] OP_SUB16 = 2'd1;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_INC  = 4'd2;
    localparam logic [3:0] ALU_DEC  = 4'd3;

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_ADJ, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [BYTE_WIDTH-1:0]   a_hi_q, a_hi_d, b_hi_q, b_hi_d;
    logic [BYTE_WIDTH-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic                    c_lo_q, c_lo_d, c_hi_q, c_hi_d, c_adj_q, c_adj_d;
    logic                    req_ready_q, req_ready_d;
    logic [BYTE_WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]              alu_opcode_q, alu_opcode_d;
    logic                    alu_enable_q, alu_enable_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [WORD_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [7:0]              rsp_flags_q, rsp_flags_d;
    logic                    rsp_flags_we_q, rsp_flags_we_d;
`ifdef ALU16_SEQ_HALF_CARRY_EN
    logic                    h_q, h_d;
`endif

    logic                    to_done, fin_c, fin_h;
    logic [BYTE_WIDTH-1:0]   fin_hi;
    logic [WORD_WIDTH-1:0]   fin_data;
    logic                    unused_flags;

    assign unused_flags = ^{alu_flags[7:5], alu_flags[3:1]};

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_hi_d         = a_hi_q;
        b_hi_d         = b_hi_q;
        res_lo_d       = res_lo_q;
        res_hi_d       = res_hi_q;
        c_lo_d         = c_lo_q;
        c_hi_d         = c_hi_q;
        c_adj_d        = c_adj_q;
        req_ready_d    = req_ready_q;
        alu_a_d        = '0;
        alu_b_d        = '0;
        alu_opcode_d   = ALU_ADD;
        alu_enable_d   = 1'b0;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_flags_d    = rsp_flags_q;
        rsp_flags_we_d = rsp_flags_we_q;
`ifdef ALU16_SEQ_HALF_CARRY_EN
        h_d            = h_q;
`endif
        to_done        = 1'b0;
        fin_hi         = res_hi_q;
        fin_c          = c_hi_q | c_adj_q;
        fin_h          = 1'b0;

        // ALU controls are registered one cycle ahead, so each branch sets up the next state's op.
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d         = req_op;
                    a_hi_d       = req_a[WORD_WIDTH-1:BYTE_WIDTH];
                    b_hi_d       = req_b[WORD_WIDTH-1:BYTE_WIDTH];
                    c_lo_d       = 1'b0;
                    c_hi_d       = 1'b0;
                    c_adj_d      = 1'b0;
                    req_ready_d  = 1'b0;
                    state_d      = S_LO;
                    alu_enable_d = 1'b1;
                    alu_a_d      = req_a[BYTE_WIDTH-1:0];
                    alu_b_d      = req_op[1] ? BYTE_WIDTH'(1) : req_b[BYTE_WIDTH-1:0];
                    alu_opcode_d = {2'b00, req_op};
                end
            end
            S_LO: begin
                res_lo_d = alu_out;
                c_lo_d   = alu_flags[0];
                state_d  = S_HI;
                if (!op_q[1]) begin
                    alu_enable_d = 1'b1;
                    alu_a_d      = a_hi_q;
                    alu_b_d      = b_hi_q;
                    alu_opcode_d = op_q[0] ? ALU_SUB : ALU_ADD;
                end
            end
            S_HI: begin
                fin_hi  = op_q[1] ? a_hi_q : alu_out;
                c_hi_d  = op_q[1] ? 1'b0 : alu_flags[0];
                c_adj_d = 1'b0;
                res_hi_d = fin_hi;
`ifdef ALU16_SEQ_HALF_CARRY_EN
                h_d = op_q[1] ? 1'b0 : alu_flags[4];
`endif
                if (c_lo_q) begin
                    state_d      = S_ADJ;
                    alu_enable_d = 1'b1;
                    alu_a_d      = fin_hi;
                    alu_b_d      = BYTE_WIDTH'(1);
                    alu_opcode_d = op_q[0] ? ALU_DEC : ALU_INC;
                end else begin
                    to_done = 1'b1;
                    fin_c   = c_hi_d;
                end
            end
            S_ADJ: begin
                fin_hi   = alu_out;
                res_hi_d = alu_out;
                c_adj_d  = alu_flags[0];
                fin_c    = c_hi_q | alu_flags[0];
`ifdef ALU16_SEQ_HALF_CARRY_EN
                h_d = h_q | alu_flags[4];
`endif
                to_done  = 1'b1;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ALU16_SEQ_HALF_CARRY_EN
        fin_h = h_d;
`endif
        fin_data = {fin_hi, res_lo_q};
        if (to_done) begin
            state_d        = S_DONE;
            rsp_valid_d    = 1'b1;
            rsp_data_d     = fin_data;
            rsp_flags_d    = {fin_data[WORD_WIDTH-1], fin_data == '0, 1'b0, fin_h,
                              2'b00, op_q == OP_SUB16, fin_c};
            rsp_flags_we_d = ~op_q[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            a_hi_q         <= '0;
            b_hi_q         <= '0;
            res_lo_q       <= '0;
            res_hi_q       <= '0;
            c_lo_q         <= 1'b0;
            c_hi_q         <= 1'b0;
            c_adj_q        <= 1'b0;
            req_ready_q    <= 1'b1;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_opcode_q   <= ALU_ADD;
            alu_enable_q   <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_flags_q    <= '0;
            rsp_flags_we_q <= 1'b0;
`ifdef ALU16_SEQ_HALF_CARRY_EN
            h_q            <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_hi_q         <= a_hi_d;
            b_hi_q         <= b_hi_d;
            res_lo_q       <= res_lo_d;
            res_hi_q       <= res_hi_d;
            c_lo_q         <= c_lo_d;
            c_hi_q         <= c_hi_d;
            c_adj_q        <= c_adj_d;
            req_ready_q    <= req_ready_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_opcode_q   <= alu_opcode_d;
            alu_enable_q   <= alu_enable_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_flags_q    <= rsp_flags_d;
            rsp_flags_we_q <= rsp_flags_we_d;
`ifdef ALU16_SEQ_HALF_CARRY_EN
            h_q            <= h_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_enable   = alu_enable_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_flags    = rsp_flags_q;
    assign rsp_flags_we = rsp_flags_we_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb/tb_alu16_sequencer.sv - randomized self-checking bench for alu16_sequencer with a byte ALU model
module tb_alu16_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_enable;
    logic [7:0]  alu_out;
    logic [7:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [7:0]  rsp_flags;
    logic        rsp_flags_we;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu16_sequencer #(.WORD_WIDTH(16), .BYTE_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_flags_we(rsp_flags_we)
    );

    // Byte ALU: 0=ADD 1=SUB 2=INC 3=DEC; junk outputs when not enabled.
    logic [8:0] alu_w;
    logic [4:0] alu_n;
    logic [7:0] alu_bb;
    logic       alu_sub;
    always_comb begin
        alu_sub = (alu_opcode == 4'd1) || (alu_opcode == 4'd3);
        alu_bb  = (alu_opcode == 4'd2 || alu_opcode == 4'd3) ? 8'd1 : alu_b;
        alu_w   = alu_sub ? ({1'b0, alu_a} - {1'b0, alu_bb}) : ({1'b0, alu_a} + {1'b0, alu_bb});
        alu_n   = alu_sub ? ({1'b0, alu_a[3:0]} - {1'b0, alu_bb[3:0]})
                          : ({1'b0, alu_a[3:0]} + {1'b0, alu_bb[3:0]});
        if (alu_enable) begin
            alu_out   = alu_w[7:0];
            alu_flags = {alu_w[7], alu_w[7:0] == 8'h00, 1'b0, alu_n[4], 2'b00, alu_sub, alu_w[8]};
        end else begin
            alu_out   = 8'hA5;
            alu_flags = 8'hFF;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 16-bit reference: whole-word arithmetic, carries read off wider sums.
    function automatic void ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output logic [7:0] f,
                                      output int lat, output logic we);
        logic        sub;
        logic [15:0] bb;
        logic [16:0] w;
        logic [12:0] h12;
        logic        lo_carry;
        logic        h;
        sub      = op[0];
        bb       = op[1] ? 16'd1 : b;
        w        = sub ? ({1'b0, a} - {1'b0, bb}) : ({1'b0, a} + {1'b0, bb});
        h12      = sub ? ({1'b0, a[11:0]} - {1'b0, bb[11:0]}) : ({1'b0, a[11:0]} + {1'b0, bb[11:0]});
        lo_carry = sub ? (a[7:0] < bb[7:0]) : ((a[7:0] + bb[7:0]) > 255);
`ifdef ALU16_SEQ_HALF_CARRY_EN
        h = h12[12];
`else
        h = 1'b0;
`endif
        r   = w[15:0];
        f   = {w[15], w[15:0] == 16'h0000, 1'b0, h, 2'b00, op == 2'd1, w[16]};
        lat = lo_carry ? 4 : 3;
        we  = ~op[1];
    endfunction

    task automatic run_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] exp_d;
        logic [7:0]  exp_f;
        int          exp_lat;
        logic        exp_we;
        int          k;
        int          en_cnt;
        ref_model(op, a, b, exp_d, exp_f, exp_lat, exp_we);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            check_eq("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1;
        en_cnt = 0;
        while (!rsp_valid && k < 12) begin
            en_cnt += int'(alu_enable);
            @(posedge clk); #1;
            k++;
        end
        check_eq("latency", k, exp_lat);
        if (!rsp_valid) return;
        check_eq("rsp_data", rsp_data, exp_d);
        check_eq("rsp_flags", rsp_flags, exp_f);
        check_eq("flags_we", rsp_flags_we, exp_we);
        check_eq("ready_in_done", req_ready, 0);
        check_eq("alu_en_done", alu_enable, 0);
        check_eq("alu_en_count", en_cnt, (op[1] ? 1 : 2) + (exp_lat == 4 ? 1 : 0));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op    = 2'($urandom_range(0, 3));
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            @(posedge clk); #1;
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_data", rsp_data, exp_d);
            check_eq("hold_flags", rsp_flags, exp_f);
            check_eq("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check_eq("release_valid", rsp_valid, 0);
        check_eq("release_ready", req_ready, 1);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h00FF;
            1:       return 16'hFFFF;
            2:       return 16'h0000;
            3:       return 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_flags", rsp_flags, 0);
        check_eq("rst_flags_we", rsp_flags_we, 0);
        check_eq("rst_alu_en", alu_enable, 0);
        check_eq("rst_alu_ab", {alu_a, alu_b}, 0);
        check_eq("rst_alu_op", alu_opcode, 0);
        @(negedge clk);
        reset = 1'b0;

        run_req(2'd0, 16'h00FF, 16'h0001, 0);
        run_req(2'd0, 16'hFFFF, 16'h0001, 0);
        run_req(2'd1, 16'h1234, 16'h0034, 0);
        run_req(2'd1, 16'h0000, 16'h0001, 1);
        run_req(2'd2, 16'h00FF, 16'h5555, 0);
        run_req(2'd3, 16'h0100, 16'hAAAA, 0);
        run_req(2'd3, 16'h0000, 16'h0000, 0);
        run_req(2'd2, 16'hFFFF, 16'h0000, 0);
        run_req(2'd0, 16'h0FFF, 16'h0001, 5);

        // Reset while the ADD16 is in HI: the request must vanish without a response.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 16'h00FF;
        req_b     = 16'h0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_alu_en", alu_enable, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", rsp_valid, 0);
        check_eq("mid_rst_alu_en", alu_enable, 0);
        check_eq("mid_rst_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid;
        end
        check_eq("rst_no_rsp", seen, 0);
        run_req(2'd0, 16'h00FF, 16'h0001, 0);

        for (int i = 0; i < 40; i++) begin
            run_req(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
